// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// A round-robin grant picks one operation at a time. The operation is latched,
// executed for one cycle, and then held in a response register until it is consumed.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_in1,
  input  logic [15:0] req0_in2,
  input  logic [2:0]  req0_op,
  input  logic        req0_flag_en,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_in1,
  input  logic [15:0] req1_in2,
  input  logic [2:0]  req1_op,
  input  logic        req1_flag_en,
  // shared ALU
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_flag_in,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flag,
  // response
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_flag,
  output logic [2:0]  flag_q
);

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  op;
    logic        flag_en;
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  op_t    [NUM_REQ-1:0] req;
  logic   [NUM_REQ-1:0] req_valid;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  op_t         opnd_q, opnd_d;
  logic        id_q, id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_flag_q, rsp_flag_d;
  logic        rsp_id_q, rsp_id_d;
  logic [2:0]  flag_d;

  logic        gnt_vld;
  logic        gnt_id;
  logic        accept;

  assign req[0]    = {req0_in1, req0_in2, req0_op, req0_flag_en};
  assign req[1]    = {req1_in1, req1_in2, req1_op, req1_flag_en};
  assign req_valid = {req1_valid, req0_valid};

  // Round-robin pick: the priority holder wins if it is asking, otherwise the other requester.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = prio_q;
    if (req_valid[prio_q]) begin
      gnt_vld = 1'b1;
      gnt_id  = prio_q;
    end else if (req_valid[~prio_q]) begin
      gnt_vld = 1'b1;
      gnt_id  = ~prio_q;
    end
  end

  // Accept only in IDLE. Reset gates the ready outputs low even before the
  // asynchronous clear has propagated through the state register.
  assign accept     = (state_q == IDLE) && gnt_vld && !rst;
  assign req0_ready = accept && (gnt_id == 1'b0);
  assign req1_ready = accept && (gnt_id == 1'b1);

  // Next-state logic for the control FSM and all datapath registers. Every register holds by default.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    opnd_d     = opnd_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    rsp_id_d   = rsp_id_q;
    flag_d     = flag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opnd_d  = req[gnt_id];
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The ALU is combinational from the operand regs, so its result is valid now.
        rsp_data_d = alu_out;
        rsp_flag_d = alu_flag;
        rsp_id_d   = id_q;
        if (opnd_q.flag_en) flag_d = alu_flag;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset is asynchronous and drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      opnd_q     <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= 16'h0000;
      rsp_flag_q <= 3'b000;
      rsp_id_q   <= 1'b0;
      flag_q     <= 3'b000;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      opnd_q     <= opnd_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_id_q   <= rsp_id_d;
      flag_q     <= flag_d;
    end
  end

  assign alu_in1     = opnd_q.in1;
  assign alu_in2     = opnd_q.in2;
  assign alu_op      = opnd_q.op;
  assign alu_flag_in = flag_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. A behavioural ALU stub drives alu_out and alu_flag.
// Directed scenarios are followed by a randomized run that is scored against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_flag_en = 1'b0, req1_flag_en = 1'b0;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op, alu_flag_in, alu_flag;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flag, flag_q;

  // Stub flag override, used to force specific flag patterns.
  logic        force_en = 1'b0;
  logic [2:0]  force_val = 3'b000;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level).
  int          m_prio;
  logic [2:0]  m_flag;
  bit          m_inflight;
  int          m_age;
  logic [15:0] m_in1, m_in2;
  logic [2:0]  m_op;
  bit          m_en, m_id;
  logic [18:0] m_res;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_op(req0_op), .req0_flag_en(req0_flag_en),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_op(req1_op), .req1_flag_en(req1_flag_en),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .flag_q(flag_q)
  );

  // ALU stub: returns {flags(Z,V,N), result}.
  function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op, input logic fen, input logic [2:0] fval);
    logic [15:0] r;
    logic        v;
    logic [2:0]  f;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a << 1;
      default: r = a >> 1;
    endcase
    f = {(r == 16'h0000), v, r[15]};
    if (fen) f = fval;
    return {f, r};
  endfunction

  assign {alu_flag, alu_out} = alu_model(alu_in1, alu_in2, alu_op, force_en, force_val);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; force_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_prio = 0; m_flag = 3'b000; m_inflight = 0; m_age = 0;
    m_in1 = '0; m_in2 = '0; m_op = '0; m_en = 0; m_id = 0;
  endtask

  task automatic test_reset();
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;  // no clock edge yet: the clear must be asynchronous
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy0 got=%0b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy1 got=%0b exp=0", req1_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%0b exp=0", rsp_id); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    checks++; if (rsp_flag !== 3'b000) begin errors++; $display("FAIL reset_rsp_flag got=%0b exp=0", rsp_flag); end
    checks++; if (flag_q !== 3'b000) begin errors++; $display("FAIL reset_flag_q got=%0b exp=0", flag_q); end
    checks++; if ({alu_in1, alu_in2, alu_op} !== 35'd0) begin errors++; $display("FAIL reset_operands got=%0h exp=0", {alu_in1, alu_in2, alu_op}); end
    checks++; if (alu_flag_in !== 3'b000) begin errors++; $display("FAIL reset_alu_flag_in got=%0b exp=0", alu_flag_in); end
    tick();
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_rdy_held got=%0b exp=00", {req0_ready, req1_ready}); end
    do_reset();
  endtask

  task automatic test_single_op();
    do_reset();
    rsp_ready = 1'b1;
    req0_in1 = 16'h0003; req0_in2 = 16'h0004; req0_op = 3'b000; req0_flag_en = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant got=%0b exp=01", {req1_ready, req0_ready}); end
    tick();  // edge T: handshake
    req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec_valid got=%0b exp=0", rsp_valid); end
    checks++; if ({alu_in1, alu_in2, alu_op} !== {16'h0003, 16'h0004, 3'b000}) begin errors++; $display("FAIL single_operands got=%0h", {alu_in1, alu_in2, alu_op}); end
    tick();  // edge T+1: result registered, presented for the consumer's edge T+2
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got=%0b exp=0", rsp_id); end
    checks++; if (rsp_data !== 16'h0007) begin errors++; $display("FAIL single_rsp_data got=%0h exp=7", rsp_data); end
    checks++; if (flag_q !== 3'b000) begin errors++; $display("FAIL single_flag_q got=%0b exp=000", flag_q); end
    tick();  // edge T+2: consumed
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got=%0b exp=0", rsp_valid); end
    checks++; if (alu_in1 !== 16'h0003) begin errors++; $display("FAIL single_opnd_hold got=%0h exp=3", alu_in1); end
  endtask

  task automatic test_alternate();
    logic [18:0] exp;
    int          id;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_in1 = 16'($urandom); req0_in2 = 16'($urandom); req0_op = 3'($urandom); req0_flag_en = 1'($urandom);
      req1_in1 = 16'($urandom); req1_in2 = 16'($urandom); req1_op = 3'($urandom); req1_flag_en = 1'($urandom);
      #1;
      id = k % 2;
      checks++; if ({req1_ready, req0_ready} !== (id == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_grant k=%0d got=%0b exp_id=%0d", k, {req1_ready, req0_ready}, id); end
      exp = (id == 0) ? alu_model(req0_in1, req0_in2, req0_op, 1'b0, 3'b0) : alu_model(req1_in1, req1_in2, req1_op, 1'b0, 3'b0);
      if ((id == 0) ? req0_flag_en : req1_flag_en) m_flag = exp[18:16];
      tick();
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL alt_busy_rdy k=%0d got=%0b exp=00", k, {req1_ready, req0_ready}); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(id)) begin errors++; $display("FAIL alt_rsp k=%0d got=%0b/%0b exp=1/%0d", k, rsp_valid, rsp_id, id); end
      checks++; if ({rsp_flag, rsp_data} !== exp) begin errors++; $display("FAIL alt_data k=%0d got=%0h exp=%0h", k, {rsp_flag, rsp_data}, exp); end
      checks++; if (flag_q !== m_flag) begin errors++; $display("FAIL alt_flag_q k=%0d got=%0b exp=%0b", k, flag_q, m_flag); end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [18:0] exp;
    do_reset();
    req1_in1 = 16'h1234; req1_in2 = 16'h0F0F; req1_op = 3'd4; req1_flag_en = 1'b0;
    exp = alu_model(16'h1234, 16'h0F0F, 3'd4, 1'b0, 3'b0);
    req1_valid = 1'b1;
    tick();            // accepted
    req0_valid = 1'b1;  // both now pending while busy
    tick();            // RESP
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_flag, rsp_data} !== exp) begin errors++; $display("FAIL bp_hold c=%0d got=%0b/%0b/%0h exp=1/1/%0h", c, rsp_valid, rsp_id, {rsp_flag, rsp_data}, exp); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_rdy c=%0d got=%0b exp=00", c, {req1_ready, req0_ready}); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%0b exp=0", rsp_valid); end
    // requester 1 was served last, so requester 0 now holds priority
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_next_grant got=%0b exp=01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_flags();
    logic       en  [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] fv  [3] = '{3'b011, 3'b101, 3'b010};
    logic [2:0] efq [3] = '{3'b011, 3'b011, 3'b010};
    do_reset();
    rsp_ready = 1'b1;
    force_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      force_val = fv[s];
      req0_in1 = 16'($urandom); req0_in2 = 16'($urandom); req0_op = 3'($urandom); req0_flag_en = en[s];
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      checks++; if (rsp_flag !== fv[s]) begin errors++; $display("FAIL flags_rsp s=%0d got=%0b exp=%0b", s, rsp_flag, fv[s]); end
      checks++; if (flag_q !== efq[s]) begin errors++; $display("FAIL flags_q s=%0d got=%0b exp=%0b", s, flag_q, efq[s]); end
      checks++; if (alu_flag_in !== efq[s]) begin errors++; $display("FAIL flags_alu_in s=%0d got=%0b exp=%0b", s, alu_flag_in, efq[s]); end
      tick();
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_exec();
    logic [18:0] exp;
    do_reset();
    rsp_ready = 1'b1;
    force_en = 1'b1; force_val = 3'b111;
    req0_in1 = 16'h00AA; req0_in2 = 16'h0055; req0_op = 3'd3; req0_flag_en = 1'b1;
    req0_valid = 1'b1;
    tick();  // accepted, now EXEC
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL rexec_async got=%0b/%0b exp=0/00", rsp_valid, {req1_ready, req0_ready}); end
    tick();
    rst = 1'b0;
    force_en = 1'b0;
    checks++; if (flag_q !== 3'b000) begin errors++; $display("FAIL rexec_flag got=%0b exp=000", flag_q); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp got=%0b exp=0", rsp_valid); end
    req0_in1 = 16'h0010; req0_in2 = 16'h0001; req0_op = 3'd1; req0_flag_en = 1'b0;
    exp = alu_model(16'h0010, 16'h0001, 3'd1, 1'b0, 3'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rexec_prio got=%0b exp=01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== exp[15:0]) begin errors++; $display("FAIL rexec_next got=%0b/%0b/%0h exp=1/0/%0h", rsp_valid, rsp_id, rsp_data, exp[15:0]); end
    tick();
  endtask

  task automatic test_req1_only();
    do_reset();
    rsp_ready = 1'b1;
    req1_in1 = 16'h8000; req1_in2 = 16'h8000; req1_op = 3'd0; req1_flag_en = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL r1only_grant got=%0b exp=10", {req1_ready, req0_ready}); end
    tick();
    req1_valid = 1'b0;
    tick();
    // 0x8000 + 0x8000 = 0 with signed overflow: Z=1 V=1 N=0
    checks++; if (rsp_id !== 1'b1 || rsp_data !== 16'h0000 || flag_q !== 3'b110) begin errors++; $display("FAIL r1only_rsp got=%0b/%0h/%0b exp=1/0/110", rsp_id, rsp_data, flag_q); end
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL r1only_ptr got=%0b exp=01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic        rr;
    int          g;
    logic [1:0]  exp_rdy;
    logic [15:0] s_in1 [2];
    logic [15:0] s_in2 [2];
    logic [2:0]  s_op  [2];
    logic        s_en  [2];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = 2'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      req0_in1 = 16'($urandom); req0_in2 = ($urandom_range(0, 7) == 0) ? req0_in1 : 16'($urandom);
      req0_op = 3'($urandom); req0_flag_en = 1'($urandom);
      req1_in1 = 16'($urandom); req1_in2 = 16'($urandom); req1_op = 3'($urandom); req1_flag_en = 1'($urandom);
      {req1_valid, req0_valid} = v; rsp_ready = rr;
      s_in1 = '{req0_in1, req1_in1}; s_in2 = '{req0_in2, req1_in2};
      s_op = '{req0_op, req1_op}; s_en = '{req0_flag_en, req1_flag_en};
      #1;
      g = -1;
      if (!m_inflight) begin
        if (v[m_prio]) g = m_prio;
        else if (v[1-m_prio]) g = 1 - m_prio;
      end
      exp_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
      checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", cyc, {req1_ready, req0_ready}, exp_rdy); end
      checks++; if (rsp_valid !== (m_inflight && m_age == 1)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b", cyc, rsp_valid); end
      if (m_inflight && m_age == 1) begin
        checks++; if ({rsp_id, rsp_flag, rsp_data} !== {m_id, m_res}) begin errors++; $display("FAIL rnd_rsp cyc=%0d got=%0h exp=%0h", cyc, {rsp_id, rsp_flag, rsp_data}, {m_id, m_res}); end
      end
      checks++; if (flag_q !== m_flag || alu_flag_in !== m_flag) begin errors++; $display("FAIL rnd_flag cyc=%0d got=%0b/%0b exp=%0b", cyc, flag_q, alu_flag_in, m_flag); end
      checks++; if ({alu_in1, alu_in2, alu_op} !== {m_in1, m_in2, m_op}) begin errors++; $display("FAIL rnd_opnd cyc=%0d got=%0h exp=%0h", cyc, {alu_in1, alu_in2, alu_op}, {m_in1, m_in2, m_op}); end
      tick();
      if (g >= 0) begin
        m_in1 = s_in1[g]; m_in2 = s_in2[g]; m_op = s_op[g]; m_en = s_en[g]; m_id = 1'(g);
        m_inflight = 1; m_age = 0; m_prio = 1 - g;
      end else if (m_inflight && m_age == 0) begin
        m_res = alu_model(m_in1, m_in2, m_op, 1'b0, 3'b0);
        if (m_en) m_flag = m_res[18:16];
        m_age = 1;
      end else if (m_inflight && rr) begin
        m_inflight = 0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_alternate();
    test_backpressure();
    test_flags();
    test_reset_exec();
    test_req1_only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
